// File: rtl/innings_ctrl.sv
// innings_ctrl: sequences one T20 innings around the LFSR ball generator.
// Optional free-hit rule after a no-ball is enabled by defining FREE_HIT_EN.
module innings_ctrl #(
  parameter int MAX_OVERS      = 20,
  parameter int MAX_WICKETS    = 10,
  parameter int BALLS_PER_OVER = 6
) (
  input  logic       i_clk_fpga,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_bowl,
  input  logic [3:0] i_lfsr_in,
  output logic       o_lfsr_rst,
  output logic       o_ready,
  output logic [3:0] o_outcome,
  output logic       o_outcome_valid,
  output logic       o_over_done,
  output logic [8:0] o_runs,
  output logic [3:0] o_wickets,
  output logic [2:0] o_balls,
  output logic [4:0] o_overs,
  output logic       o_innings_done
);

  localparam logic [4:0] LP_MAX_OVERS   = 5'(MAX_OVERS);
  localparam logic [3:0] LP_MAX_WICKETS = 4'(MAX_WICKETS);
  localparam logic [2:0] LP_LAST_BALL   = 3'(BALLS_PER_OVER - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_lfsr_rst;
  logic       r_ready;
  logic [3:0] r_outcome;
  logic       r_outcome_valid;
  logic       r_over_done;
  logic [8:0] r_runs;
  logic [3:0] r_wickets;
  logic [2:0] r_balls;
  logic [4:0] r_overs;
  logic       r_innings_done;
`ifdef FREE_HIT_EN
  logic       r_free_hit;
  logic       w_free_hit_nx;
`endif

  logic [4:0] w_dec;
  logic [2:0] w_add;
  logic       w_legal;
  logic       w_wicket;
  logic [9:0] w_sum;
  logic [8:0] w_runs_nx;
  logic [3:0] w_wickets_nx;
  logic [2:0] w_balls_nx;
  logic [4:0] w_overs_nx;
  logic       w_over_nx;
  logic       w_end;

  // Code -> {runs to add[2:0], legal ball, wicket}
  function automatic logic [4:0] f_decode(input logic [3:0] code);
    case (code)
      4'd0, 4'd1, 4'd2:         f_decode = {3'd0, 1'b1, 1'b0};
      4'd3, 4'd4, 4'd5, 4'd6:   f_decode = {3'd1, 1'b1, 1'b0};
      4'd7, 4'd8, 4'd9:         f_decode = {3'd2, 1'b1, 1'b0};
      4'd10:                    f_decode = {3'd3, 1'b1, 1'b0};
      4'd11:                    f_decode = {3'd4, 1'b1, 1'b0};
      4'd12:                    f_decode = {3'd6, 1'b1, 1'b0};
      4'd13, 4'd14:             f_decode = {3'd1, 1'b0, 1'b0};
      4'd15:                    f_decode = {3'd0, 1'b1, 1'b1};
      default:                  f_decode = 5'd0;
    endcase
  endfunction

  // Next counter values for the delivery held in r_outcome
  always_comb begin
    w_dec   = f_decode(r_outcome);
    w_add   = w_dec[4:2];
    w_legal = w_dec[1];
`ifdef FREE_HIT_EN
    // A wicket code on a free hit is a plain legal dot
    if (r_free_hit && (r_outcome == 4'd15)) begin
      w_wicket = 1'b0;
    end else begin
      w_wicket = w_dec[0];
    end
    if (r_outcome == 4'd14) begin
      w_free_hit_nx = 1'b1;
    end else if (r_outcome == 4'd13) begin
      w_free_hit_nx = r_free_hit;
    end else begin
      w_free_hit_nx = 1'b0;
    end
`else
    w_wicket = w_dec[0];
`endif
    w_sum = {1'b0, r_runs} + {7'd0, w_add};
    if (w_sum[9]) begin
      w_runs_nx = 9'd511;
    end else begin
      w_runs_nx = w_sum[8:0];
    end
    w_wickets_nx = r_wickets + {3'd0, w_wicket};
    w_balls_nx   = r_balls;
    w_overs_nx   = r_overs;
    w_over_nx    = 1'b0;
    if (w_legal) begin
      if (r_balls == LP_LAST_BALL) begin
        w_balls_nx = 3'd0;
        w_overs_nx = r_overs + 5'd1;
        w_over_nx  = 1'b1;
      end else begin
        w_balls_nx = r_balls + 3'd1;
      end
    end else begin
      w_balls_nx = r_balls;
    end
    w_end = (w_wickets_nx == LP_MAX_WICKETS) || (w_overs_nx == LP_MAX_OVERS);
  end

  // Innings FSM with all outputs registered
  always_ff @(posedge i_clk_fpga or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= ST_IDLE;
      r_lfsr_rst      <= 1'b1;
      r_ready         <= 1'b0;
      r_outcome       <= 4'd0;
      r_outcome_valid <= 1'b0;
      r_over_done     <= 1'b0;
      r_runs          <= 9'd0;
      r_wickets       <= 4'd0;
      r_balls         <= 3'd0;
      r_overs         <= 5'd0;
      r_innings_done  <= 1'b0;
`ifdef FREE_HIT_EN
      r_free_hit      <= 1'b0;
`endif
    end else begin
      r_outcome_valid <= 1'b0;
      r_over_done     <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state        <= ST_READY;
            r_lfsr_rst     <= 1'b0;
            r_ready        <= 1'b1;
            r_innings_done <= 1'b0;
            r_outcome      <= 4'd0;
            r_runs         <= 9'd0;
            r_wickets      <= 4'd0;
            r_balls        <= 3'd0;
            r_overs        <= 5'd0;
`ifdef FREE_HIT_EN
            r_free_hit     <= 1'b0;
`endif
          end
        end
        ST_READY: begin
          if (i_bowl) begin
            r_state   <= ST_SAMPLE;
            r_ready   <= 1'b0;
            r_outcome <= i_lfsr_in;
          end
        end
        ST_SAMPLE: begin
          r_runs          <= w_runs_nx;
          r_wickets       <= w_wickets_nx;
          r_balls         <= w_balls_nx;
          r_overs         <= w_overs_nx;
          r_outcome_valid <= 1'b1;
          r_over_done     <= w_over_nx;
`ifdef FREE_HIT_EN
          r_free_hit      <= w_free_hit_nx;
`endif
          if (w_end) begin
            r_state        <= ST_DONE;
            r_innings_done <= 1'b1;
          end else begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_lfsr_rst <= 1'b1;
          r_ready    <= 1'b0;
        end
      endcase
    end
  end

  assign o_lfsr_rst      = r_lfsr_rst;
  assign o_ready         = r_ready;
  assign o_outcome       = r_outcome;
  assign o_outcome_valid = r_outcome_valid;
  assign o_over_done     = r_over_done;
  assign o_runs          = r_runs;
  assign o_wickets       = r_wickets;
  assign o_balls         = r_balls;
  assign o_overs         = r_overs;
  assign o_innings_done  = r_innings_done;

endmodule

// File: tb/tb_innings_ctrl.sv
// Directed bench for innings_ctrl: default instance plus a one-over instance.
module tb_innings_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       bowl = 1'b0;
  logic [3:0] lfsr = 4'd0;

  logic       lfsr_rst, ready, outcome_valid, over_done, innings_done;
  logic [3:0] outcome, wickets;
  logic [8:0] runs;
  logic [2:0] balls;
  logic [4:0] overs;

  logic       d1_lfsr_rst, d1_ready, d1_outcome_valid, d1_over_done, d1_innings_done;
  logic [3:0] d1_outcome, d1_wickets;
  logic [8:0] d1_runs;
  logic [2:0] d1_balls;
  logic [4:0] d1_overs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  innings_ctrl u_dut (
    .i_clk_fpga(clk), .i_reset(reset), .i_start(start), .i_bowl(bowl), .i_lfsr_in(lfsr),
    .o_lfsr_rst(lfsr_rst), .o_ready(ready), .o_outcome(outcome),
    .o_outcome_valid(outcome_valid), .o_over_done(over_done), .o_runs(runs),
    .o_wickets(wickets), .o_balls(balls), .o_overs(overs), .o_innings_done(innings_done)
  );

  innings_ctrl #(.MAX_OVERS(1)) u_dut1 (
    .i_clk_fpga(clk), .i_reset(reset), .i_start(start), .i_bowl(bowl), .i_lfsr_in(lfsr),
    .o_lfsr_rst(d1_lfsr_rst), .o_ready(d1_ready), .o_outcome(d1_outcome),
    .o_outcome_valid(d1_outcome_valid), .o_over_done(d1_over_done), .o_runs(d1_runs),
    .o_wickets(d1_wickets), .o_balls(d1_balls), .o_overs(d1_overs),
    .o_innings_done(d1_innings_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the edge on which counters update.
  task automatic bowl_ball(input logic [3:0] code);
    bowl = 1'b1;
    lfsr = code;
    @(posedge clk); #1;
    bowl = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic new_innings();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    pulse_start();
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_lfsr_rst", lfsr_rst, 1);
    chk("rst_ready", ready, 0);
    chk("rst_runs", runs, 0);
    chk("rst_outcome", outcome, 0);
    chk("rst_valid", outcome_valid, 0);
    chk("rst_done", innings_done, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_lfsr_rst", lfsr_rst, 1);

    // Test 1: start then a six
    pulse_start();
    chk("t1_lfsr_rst", lfsr_rst, 0);
    chk("t1_ready", ready, 1);
    bowl_ball(4'd12);
    chk("t1_valid", outcome_valid, 1);
    chk("t1_runs", runs, 6);
    chk("t1_balls", balls, 1);
    chk("t1_outcome", outcome, 12);
    chk("t1_over_done", over_done, 0);
    @(posedge clk); #1;
    chk("t1_valid_drop", outcome_valid, 0);
    chk("t1_outcome_hold", outcome, 12);

    // Test 2: six singles complete an over
    new_innings();
    for (int i = 0; i < 6; i++) begin
      bowl_ball(4'd3);
      chk("t2_over_done", over_done, (i == 5) ? 1 : 0);
    end
    chk("t2_runs", runs, 6);
    chk("t2_balls", balls, 0);
    chk("t2_overs", overs, 1);

    // Test 3: wide then no-ball are not legal
    new_innings();
    bowl_ball(4'd13);
    chk("t3_od_wide", over_done, 0);
    bowl_ball(4'd14);
    chk("t3_od_nb", over_done, 0);
    chk("t3_runs", runs, 2);
    chk("t3_balls", balls, 0);
    chk("t3_overs", overs, 0);

    // Test 4: no-ball then wicket code, then another wicket code
    new_innings();
    bowl_ball(4'd14);
    bowl_ball(4'd15);
    chk("t4_runs", runs, 1);
    chk("t4_balls", balls, 1);
`ifdef FREE_HIT_EN
    chk("t4_wickets", wickets, 0);
`else
    chk("t4_wickets", wickets, 1);
`endif
    bowl_ball(4'd15);
    chk("t4_balls2", balls, 2);
`ifdef FREE_HIT_EN
    chk("t4_wickets2", wickets, 1);
`else
    chk("t4_wickets2", wickets, 2);
`endif

    // Test 5: ten wickets end the innings
    new_innings();
    for (int i = 0; i < 10; i++) begin
      chk("t5_not_done", innings_done, 0);
      bowl_ball(4'd15);
    end
    chk("t5_wickets", wickets, 10);
    chk("t5_done", innings_done, 1);
    chk("t5_ready", ready, 0);
    chk("t5_overs", overs, 1);
    chk("t5_balls", balls, 4);
    bowl_ball(4'd12);
    chk("t5_ign_valid", outcome_valid, 0);
    chk("t5_ign_runs", runs, 0);
    chk("t5_ign_outcome", outcome, 15);
    chk("t5_ign_wickets", wickets, 10);
    pulse_start();
    chk("t5_rs_ready", ready, 1);
    chk("t5_rs_done", innings_done, 0);
    chk("t5_rs_wickets", wickets, 0);
    chk("t5_rs_overs", overs, 0);
    chk("t5_rs_balls", balls, 0);
    chk("t5_rs_outcome", outcome, 0);
    chk("t5_rs_lfsr_rst", lfsr_rst, 0);

    // Saturation: 85 sixes give 510, the 86th clamps to 511
    for (int i = 0; i < 85; i++) bowl_ball(4'd12);
    chk("sat_510", runs, 510);
    bowl_ball(4'd12);
    chk("sat_511", runs, 511);
    chk("sat_overs", overs, 14);
    chk("sat_balls", balls, 2);
    chk("sat_not_done", innings_done, 0);

    // Test 6a: one-over instance, wicket on the last ball
    new_innings();
    for (int i = 0; i < 5; i++) bowl_ball(4'd0);
    chk("t6_d1_pre", d1_innings_done, 0);
    bowl_ball(4'd15);
    chk("t6_d1_done", d1_innings_done, 1);
    chk("t6_d1_wickets", d1_wickets, 1);
    chk("t6_d1_overs", d1_overs, 1);
    chk("t6_d1_balls", d1_balls, 0);
    chk("t6_d1_over_done", d1_over_done, 1);
    chk("t6_d1_valid", d1_outcome_valid, 1);
    chk("t6_d0_not_done", innings_done, 0);

    // Test 6b: six legal balls end a one-over innings
    new_innings();
    for (int i = 0; i < 6; i++) bowl_ball(4'd2);
    chk("t6b_d1_done", d1_innings_done, 1);
    chk("t6b_d1_wickets", d1_wickets, 0);
    chk("t6b_d1_runs", d1_runs, 0);

    // Test 6c: reset while the delivery is in SAMPLE
    pulse_start();
    chk("t6c_ready", d1_ready, 1);
    bowl = 1'b1;
    lfsr = 4'd12;
    @(posedge clk); #1;
    bowl = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("t6c_lfsr_rst", d1_lfsr_rst, 1);
    chk("t6c_outcome", d1_outcome, 0);
    chk("t6c_runs", d1_runs, 0);
    chk("t6c_ready0", d1_ready, 0);
    @(posedge clk); #1;
    chk("t6c_valid", d1_outcome_valid, 0);
    chk("t6c_runs2", d1_runs, 0);
    chk("t6c_balls", d1_balls, 0);
    chk("t6c_done", d1_innings_done, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
